// File: rtl/row_sequencer_pkg.sv
// Shared types and widths for the classification row sequencer.
// Holds the FSM state encoding and the argmax update rule.
package seq_pkg;

   localparam int ROW_W = 4;
   localparam int RES_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_STORE,
      S_FINISH,
      S_ABORT
   } state_t;

   // Row 0 always seeds the argmax; later rows must be strictly larger, so ties keep the lowest index.
   function automatic logic beats_best(input logic [ROW_W-1:0] row,
                                       input logic [RES_W-1:0] cand,
                                       input logic [RES_W-1:0] best);
      return (row == '0) || (cand > best);
   endfunction

endpackage

// File: rtl/row_sequencer_if.sv
// Handshake and result bus between the row sequencer, the per-row multiplier
// and the result memory.
interface row_sequencer_if;
   import seq_pkg::*;

   logic             start;
   logic             done_row;
   logic [RES_W-1:0] row_result;
   logic             begin_mult;
   logic [ROW_W-1:0] row_select;
   logic             result_we;
   logic [ROW_W-1:0] result_addr;
   logic [RES_W-1:0] result_data;
   logic             busy;
   logic             done;
   logic [ROW_W-1:0] class_out;
   logic [RES_W-1:0] class_score;
   logic             timeout_err;

   modport master (
      input  start, done_row, row_result,
      output begin_mult, row_select, result_we, result_addr, result_data,
             busy, done, class_out, class_score, timeout_err
   );

   modport slave (
      output start, done_row, row_result,
      input  begin_mult, row_select, result_we, result_addr, result_data,
             busy, done, class_out, class_score, timeout_err
   );

endinterface

// File: rtl/flex_counter.sv
// Clearable up-counter used as the per-row watchdog. rollover_flag is
// combinational: high on the enabled cycle that brings the count to rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic                    rollover_flag
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic                    reach;

   assign reach         = count_enable && ((count_q + ONE) == rollover_val);
   assign rollover_flag = reach;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = reach ? '0 : count_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/row_sequencer.sv
// Drives the row multiplier through NUM_ROWS rows, stores each row sum and
// tracks the running argmax; a watchdog aborts the pass on a stalled row.
module row_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_ROWS       = 10,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic             clk,
   input logic             rst,
   row_sequencer_if.master bus
);

   localparam int                  WD_BITS  = 10;
   localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(NUM_ROWS - 1);
   localparam logic [ROW_W-1:0]    ROW_ONE  = ROW_W'(1);
   localparam logic [WD_BITS-1:0]  WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES);

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [RES_W-1:0] cap_q, cap_d;
   logic [ROW_W-1:0] best_idx_q, best_idx_d;
   logic [RES_W-1:0] best_score_q, best_score_d;
   logic [ROW_W-1:0] class_out_q, class_out_d;
   logic [RES_W-1:0] class_score_q, class_score_d;
   logic             timeout_err_q, timeout_err_d;

   logic             wd_clear;
   logic             wd_en;
   logic             wd_timeout;

   assign wd_clear = (state_q == S_ISSUE);
   assign wd_en    = (state_q == S_WAIT);

   flex_counter #(
      .NUM_CNT_BITS (WD_BITS)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .clear         (wd_clear),
      .count_enable  (wd_en),
      .rollover_val  (WD_LIMIT),
      .rollover_flag (wd_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A completing row wins over a watchdog expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.start) state_d = S_ISSUE;
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT: begin
            if (bus.done_row) begin
               state_d = S_STORE;
            end else if (wd_timeout) begin
               state_d = S_ABORT;
            end
         end
         S_STORE:  state_d = (row_q == LAST_ROW) ? S_FINISH : S_ISSUE;
         S_ABORT:  state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.begin_mult  = (state_q == S_ISSUE);
      bus.result_we   = (state_q == S_STORE);
      bus.done        = (state_q == S_FINISH);
      bus.busy        = (state_q != S_IDLE);
      bus.row_select  = row_q;
      bus.result_addr = (state_q == S_STORE) ? row_q : '0;
      bus.result_data = (state_q == S_STORE) ? cap_q : '0;
      bus.class_out   = class_out_q;
      bus.class_score = class_score_q;
      bus.timeout_err = timeout_err_q;
   end

   // The row counter only advances on the STORE->ISSUE edge so row_select holds for the whole row.
   always_comb begin
      row_d         = row_q;
      cap_d         = cap_q;
      best_idx_d    = best_idx_q;
      best_score_d  = best_score_q;
      class_out_d   = class_out_q;
      class_score_d = class_score_q;
      timeout_err_d = timeout_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               row_d         = '0;
               timeout_err_d = 1'b0;
               best_idx_d    = '0;
               best_score_d  = '0;
            end
         end
         S_WAIT: begin
            if (bus.done_row) begin
               cap_d = bus.row_result;
            end
         end
         S_STORE: begin
            if (beats_best(row_q, cap_q, best_score_q)) begin
               best_idx_d   = row_q;
               best_score_d = cap_q;
            end
            if (row_q != LAST_ROW) begin
               row_d = row_q + ROW_ONE;
            end
         end
         S_ABORT: timeout_err_d = 1'b1;
         S_FINISH: begin
            class_out_d   = best_idx_q;
            class_score_d = best_score_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q         <= '0;
         cap_q         <= '0;
         best_idx_q    <= '0;
         best_score_q  <= '0;
         class_out_q   <= '0;
         class_score_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         row_q         <= row_d;
         cap_q         <= cap_d;
         best_idx_q    <= best_idx_d;
         best_score_q  <= best_score_d;
         class_out_q   <= class_out_d;
         class_score_q <= class_score_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_row_sequencer.sv
// Bench for row_sequencer: multiplier responder, bus monitor, table-driven and
// randomized classification passes, plus reset and start-hold sequences.
module tb_row_sequencer;

   localparam int NR = 10;
   localparam int TO = 16;

   typedef struct {
      string       name;
      logic [15:0] res [NR];
      int          lat;
      int          silent;
      int          exp_class;
      int          exp_score;
      bit          exp_to;
      int          exp_writes;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   row_sequencer_if bus ();

   row_sequencer #(
      .NUM_ROWS       (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] cfg_res [NR];
   int          cfg_lat    = 3;
   int          cfg_silent = -1;
   int          stray_cnt  = 0;

   int          cyc      = 0;
   int          stab_err = 0;
   int          bm_cyc_q [$];
   int          done_cyc_q [$];
   logic [3:0]  wr_addr_q [$];
   logic [15:0] wr_data_q [$];

   // Multiplier model: answers each begin_mult after cfg_lat cycles unless the row is silent.
   initial begin : responder
      int          cnt;
      bit          pend;
      int          stray_seen;
      logic [15:0] val;
      pend = 1'b0; cnt = 0; stray_seen = 0; val = '0;
      bus.done_row   = 1'b0;
      bus.row_result = 16'hDEAD;
      forever begin
         @(posedge clk);
         #1;
         bus.done_row   = 1'b0;
         bus.row_result = 16'hDEAD;
         if (rst) begin
            pend = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.done_row   = 1'b1;
               bus.row_result = val;
               pend           = 1'b0;
            end
         end
         if (!rst && bus.begin_mult && cfg_silent != int'(bus.row_select)) begin
            pend = 1'b1;
            cnt  = cfg_lat;
            val  = cfg_res[bus.row_select];
         end
         if (stray_cnt != stray_seen) begin
            stray_seen     = stray_cnt;
            bus.done_row   = 1'b1;
            bus.row_result = 16'h7777;
         end
      end
   end

   initial begin : monitor
      logic [3:0] prev_row;
      bit         prev_busy;
      bit         prev_we;
      prev_row = '0; prev_busy = 1'b0; prev_we = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.begin_mult) bm_cyc_q.push_back(cyc);
         if (bus.done)       done_cyc_q.push_back(cyc);
         if (bus.result_we) begin
            wr_addr_q.push_back(bus.result_addr);
            wr_data_q.push_back(bus.result_data);
         end
         if (bus.busy && prev_busy && !prev_we && bus.row_select != prev_row) stab_err++;
         prev_row  = bus.row_select;
         prev_busy = bus.busy;
         prev_we   = bus.result_we;
      end
   end

   initial begin : global_guard
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic vec_t mkv(input string name, input logic [15:0] r [NR], input int lat,
                                input int silent, input int cls, input int score,
                                input bit to, input int nwr);
      vec_t v;
      v.name = name; v.res = r; v.lat = lat; v.silent = silent;
      v.exp_class = cls; v.exp_score = score; v.exp_to = to; v.exp_writes = nwr;
      return v;
   endfunction

   // Reference: rows before the silent one are stored; prediction is the first index holding the maximum.
   function automatic void ref_model(inout vec_t v);
      int stored [$];
      int mx;
      int idx [$];
      v.exp_to     = (v.silent >= 0);
      v.exp_writes = v.exp_to ? v.silent : NR;
      for (int i = 0; i < v.exp_writes; i++) stored.push_back(int'(v.res[i]));
      if (stored.size() == 0) begin
         v.exp_class = 0;
         v.exp_score = 0;
      end else begin
         mx = stored.max()[0];
         idx = stored.find_first_index(x) with (x == mx);
         v.exp_class = idx[0];
         v.exp_score = mx;
      end
   endfunction

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         if (done_cyc_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_pass(input vec_t v);
      int b_wr, b_bm, b_dn, b_st, st, n_bm, n_wr, bad_gap, last_bm;
      bit ok;
      b_wr = wr_addr_q.size(); b_bm = bm_cyc_q.size();
      b_dn = done_cyc_q.size(); b_st = stab_err;
      cfg_res = v.res; cfg_lat = v.lat; cfg_silent = v.silent;
      @(posedge clk); #2;
      bus.start = 1'b1;
      st = cyc + 1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      wait_done(b_dn + 1, ok);
      check({v.name, ".done_seen"}, 32'(ok), 32'd1);
      #2;
      check({v.name, ".busy_after"}, 32'(bus.busy), 32'd0);
      check({v.name, ".done_pulses"}, 32'(done_cyc_q.size() - b_dn), 32'd1);
      n_bm = bm_cyc_q.size() - b_bm;
      check({v.name, ".begin_mults"}, 32'(n_bm), 32'(v.exp_to ? v.silent + 1 : NR));
      if (n_bm > 0) begin
         check({v.name, ".start_latency"}, 32'(bm_cyc_q[b_bm] - st), 32'd1);
         bad_gap = 0;
         for (int i = 1; i < n_bm; i++)
            if (bm_cyc_q[b_bm+i] - bm_cyc_q[b_bm+i-1] != v.lat + 2) bad_gap++;
         check({v.name, ".row_spacing_errs"}, 32'(bad_gap), 32'd0);
         last_bm = bm_cyc_q[b_bm + n_bm - 1];
         if (ok) check({v.name, ".end_latency"}, 32'(done_cyc_q[b_dn] - last_bm),
                       32'(2 + (v.exp_to ? TO : v.lat)));
      end
      n_wr = wr_addr_q.size() - b_wr;
      check({v.name, ".writes"}, 32'(n_wr), 32'(v.exp_writes));
      for (int i = 0; i < n_wr && i < v.exp_writes; i++) begin
         check($sformatf("%s.addr%0d", v.name, i), 32'(wr_addr_q[b_wr+i]), 32'(i));
         check($sformatf("%s.data%0d", v.name, i), 32'(wr_data_q[b_wr+i]), 32'(v.res[i]));
      end
      check({v.name, ".class_out"}, 32'(bus.class_out), 32'(v.exp_class));
      check({v.name, ".class_score"}, 32'(bus.class_score), 32'(v.exp_score));
      check({v.name, ".timeout_err"}, 32'(bus.timeout_err), 32'(v.exp_to));
      check({v.name, ".row_stable_errs"}, 32'(stab_err - b_st), 32'd0);
   endtask

   initial begin : main
      vec_t tbl [7];
      vec_t rv;
      int   b_wr, b_bm, b_dn, b_st, n;
      bit   ok, ok2;

      tbl[0] = mkv("normal", '{16'd10, 16'd50, 16'd20, 16'd5, 16'd7, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4},
                   3, -1, 1, 50, 1'b0, 10);
      tbl[1] = mkv("tie", '{16'h10, 16'h10, 16'h10, 16'h100, 16'h10, 16'h10, 16'h10, 16'h100, 16'h10, 16'h10},
                   3, -1, 3, 256, 1'b0, 10);
      tbl[2] = mkv("timeout", '{16'd7, 16'd3, 16'd9, 16'd9, 16'd100, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1},
                   3, 4, 2, 9, 1'b1, 4);
      tbl[3] = mkv("lat_eq_limit", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd200},
                   16, -1, 9, 200, 1'b0, 10);
      tbl[4] = mkv("lat1_flat", '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5},
                   1, -1, 0, 5, 1'b0, 10);
      tbl[5] = mkv("silent_row0", '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9},
                   2, 0, 0, 0, 1'b1, 0);
      tbl[6] = mkv("silent_last", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd300, 16'd999},
                   4, 9, 8, 300, 1'b1, 9);

      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst.begin_mult",  32'(bus.begin_mult),  32'd0);
      check("rst.result_we",   32'(bus.result_we),   32'd0);
      check("rst.done",        32'(bus.done),        32'd0);
      check("rst.busy",        32'(bus.busy),        32'd0);
      check("rst.timeout_err", 32'(bus.timeout_err), 32'd0);
      check("rst.class_out",   32'(bus.class_out),   32'd0);
      check("rst.class_score", 32'(bus.class_score), 32'd0);
      check("rst.row_select",  32'(bus.row_select),  32'd0);
      check("rst.result_addr", 32'(bus.result_addr), 32'd0);
      check("rst.result_data", 32'(bus.result_data), 32'd0);
      rst = 1'b0;

      // done_row while idle must not write or wake the sequencer
      b_wr = wr_addr_q.size();
      @(posedge clk); #2;
      stray_cnt++;
      repeat (4) @(posedge clk);
      #2;
      check("idle_stray.writes", 32'(wr_addr_q.size() - b_wr), 32'd0);
      check("idle_stray.busy",   32'(bus.busy), 32'd0);

      for (int i = 0; i < 7; i++) run_pass(tbl[i]);

      for (int k = 0; k < 6; k++) begin
         rv.name = $sformatf("rand%0d", k);
         for (int r = 0; r < NR; r++) rv.res[r] = 16'($urandom_range(0, 7));
         rv.lat    = int'($urandom_range(1, 16));
         rv.silent = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
         ref_model(rv);
         run_pass(rv);
      end

      // start held high: back-to-back passes, one begin_mult per row each
      b_wr = wr_addr_q.size(); b_bm = bm_cyc_q.size();
      b_dn = done_cyc_q.size(); b_st = stab_err;
      cfg_res = tbl[0].res; cfg_lat = 3; cfg_silent = -1;
      @(posedge clk); #2;
      bus.start = 1'b1;
      wait_done(b_dn + 1, ok);
      wait_done(b_dn + 2, ok2);
      #2;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("hold.both_done",   32'(ok && ok2), 32'd1);
      check("hold.begin_mults", 32'(bm_cyc_q.size() - b_bm), 32'd20);
      check("hold.done_pulses", 32'(done_cyc_q.size() - b_dn), 32'd2);
      check("hold.writes",      32'(wr_addr_q.size() - b_wr), 32'd20);
      check("hold.class_out",   32'(bus.class_out), 32'd1);
      check("hold.class_score", 32'(bus.class_score), 32'd50);
      check("hold.row_stable",  32'(stab_err - b_st), 32'd0);
      check("hold.busy",        32'(bus.busy), 32'd0);

      // reset while waiting on row 2
      b_wr = wr_addr_q.size(); b_bm = bm_cyc_q.size();
      cfg_res = tbl[0].res; cfg_lat = 10; cfg_silent = -1;
      @(posedge clk); #2;
      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         if (bm_cyc_q.size() >= b_bm + 3) begin
            ok = 1'b1;
            break;
         end
      end
      check("midrst.row2_issued", 32'(ok), 32'd1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst.busy",        32'(bus.busy), 32'd0);
      check("midrst.begin_mult",  32'(bus.begin_mult), 32'd0);
      check("midrst.result_we",   32'(bus.result_we), 32'd0);
      check("midrst.row_select",  32'(bus.row_select), 32'd0);
      check("midrst.class_out",   32'(bus.class_out), 32'd0);
      check("midrst.class_score", 32'(bus.class_score), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      n = bm_cyc_q.size();
      repeat (15) @(posedge clk);
      #2;
      check("midrst.no_more_begin", 32'(bm_cyc_q.size() - n), 32'd0);
      check("midrst.writes",        32'(wr_addr_q.size() - b_wr), 32'd2);
      check("midrst.idle",          32'(bus.busy), 32'd0);

      tbl[0].name = "after_reset";
      run_pass(tbl[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/row_sequencer.md
# row_sequencer

Top-level row scheduler for the fully-connected classification stage. It drives the per-row multiplier through all output rows: set `row_select`, pulse `begin_mult`, wait for `done_row`, capture `row_result`. Each row result is written to the result memory, and a running argmax produces the predicted class. A watchdog aborts the pass if a row never completes.

## Interface
- `NUM_ROWS`, default 10: number of output rows per pass, 1..16.
- `TIMEOUT_CYCLES`, default 1000: maximum WAIT cycles per row before abort, 2..1023.

- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request one classification pass. Sampled only in IDLE.
- `done_row`, in, 1: row-complete pulse from the multiplier.
- `row_result`, in, 16: multiplier row sum, unsigned. Valid in the cycle `done_row` is high.
- `begin_mult`, out, 1: one-cycle start pulse to the multiplier.
- `row_select`, out, 4: current row index.
- `result_we`, out, 1: result-memory write strobe.
- `result_addr`, out, 4: result-memory write address.
- `result_data`, out, 16: result-memory write data.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle end-of-pass pulse.
- `class_out`, out, 4: argmax row index.
- `class_score`, out, 16: `row_result` value of the argmax row.
- `timeout_err`, out, 1: sticky abort flag. Cleared by the next accepted `start`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, STORE, FINISH, ABORT.
- IDLE
  - If `start`=1: go to ISSUE.
  - On that transition: row counter ← 0, `timeout_err` ← 0, best score/index ← 0.
- ISSUE
  - `begin_mult`=1 for exactly this cycle.
  - Watchdog cleared.
  - Go to WAIT.
- WAIT
  - If `done_row`=1: capture `row_result`, go to STORE.
  - Else if the watchdog reaches `TIMEOUT_CYCLES`: go to ABORT.
  - `done_row` takes priority when both occur in the same cycle.
- STORE
  - `result_we`=1, `result_addr`=row, `result_data`=captured value.
  - Update the argmax if row==0 or captured > best (strict compare). On ties the lowest index wins.
  - If row==`NUM_ROWS`-1: go to FINISH. Else row++ and go to ISSUE.
- ABORT: `timeout_err` ← 1, go to FINISH. Argmax keeps the best of the rows already stored.
- FINISH
  - `done`=1 for this cycle.
  - `class_out`/`class_score` are loaded from best index/score on this cycle's closing edge and held until the next pass's FINISH.
  - Go to IDLE.
- `row_select` equals the row counter and is stable from ISSUE through STORE, because the multiplier uses it for addressing during the whole row.
- Ignored inputs:
  - `start` is ignored in all states except IDLE.
  - `done_row` is ignored in all states except WAIT.
- Reset, asserted at any time including mid-row:
  - State → IDLE.
  - All outputs 0: `begin_mult`, `result_we`, `done`, `busy`, `timeout_err`, `class_out`, `class_score`, `row_select`, `result_addr`, `result_data`.
  - No partial write is completed.

## Timing
- `start` sampled at edge k → ISSUE in cycle k+1 (`begin_mult` high) → WAIT from cycle k+2.
- `done_row` sampled at edge j → STORE in cycle j+1 → the next row's ISSUE in cycle j+2.
- Overhead per row is 2 cycles plus multiplier latency.
- After the last STORE: FINISH (`done`) in the next cycle, IDLE in the one after. `busy` falls in the same cycle as IDLE is entered.
- Timeout: ABORT is entered after exactly `TIMEOUT_CYCLES` WAIT cycles without `done_row`; FINISH follows in the next cycle.
- `begin_mult`, `result_we`, `done` and `busy` are decoded from the state register (Moore). `class_out`/`class_score` are registered.

## Structure
- Package `seq_pkg` holds:
  - the state enum,
  - row-index width `ROW_W`=4,
  - result width `RES_W`=16.
- Watchdog sub-module: `flex_counter` instance with `NUM_CNT_BITS`=10, `rollover_val`=`TIMEOUT_CYCLES`, `clear` = (state==ISSUE), `count_enable` = (state==WAIT). Its `rollover_flag` is the timeout event.
- Row counter, capture register and argmax registers are local.

## Test plan
1. Reset: assert `rst` for 3 cycles → all outputs 0, `busy`=0. A `done_row` pulse in IDLE causes no write.
2. Normal pass: model responds with `done_row` 3 cycles after `begin_mult`, results 10,50,20,5,7,9,1,2,3,4 → 10 writes to addresses 0..9 in order, `class_out`=1, `class_score`=50, one `done` pulse, `timeout_err`=0.
3. Tie: rows 3 and 7 both return 0x0100, all other rows 0x0010 → `class_out`=3, `class_score`=0x0100.
4. Timeout: `TIMEOUT_CYCLES`=16, model silent on row 4 → writes to rows 0..3 only, ABORT after 16 WAIT cycles, `timeout_err`=1, `done` pulse, argmax taken from rows 0..3.
5. Robustness:
   - `start` held high throughout a pass → exactly one `begin_mult` per row.
   - `start` still high in IDLE → a second pass begins.
   - `row_select` stays constant across every WAIT.
6. Reset mid-WAIT on row 2 → IDLE on the next cycle with no further `begin_mult`. A fresh `start` then completes a full 10-row pass.
